// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider controller slice.
//   state_t   - controller FSM states
//   MIN_DIV   - smallest ratio accepted through the config handshake
//   high_len  - number of high cycles in one div_clk period for ratio n
package clk_div_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam int unsigned MIN_DIV = 2;

  // High phase is the larger half for odd ratios: N=5 -> 3 high, 2 low.
  function automatic int unsigned high_len(input int unsigned n);
    return (n + 1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter and registered waveform generator.
//   clk, reset - system clock, asynchronous active-high reset
//   ratio      - divide ratio N in effect for the current period
//   run        - controller is in RUN; counter advances
//   start      - begin a fresh period on the next cycle (cnt=0, div_clk=1, tick=1)
//   div_clk    - registered divided waveform, high while cnt < high_len(N)
//   tick       - one-cycle pulse on the first cycle of each period
//   boundary   - combinational: current cycle is the last of the period
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] ratio,
  input  logic             run,
  input  logic             start,
  output logic             div_clk,
  output logic             tick,
  output logic             boundary
);

  localparam int unsigned CW = DIV_W + 1;

  logic [DIV_W-1:0] cnt;
  logic [CW-1:0]    cnt_inc;
  logic [CW-1:0]    high_cnt;

  // One extra bit so the increment and the N=2**DIV_W-1 high length never overflow.
  assign cnt_inc  = {1'b0, cnt} + CW'(1);
  assign high_cnt = CW'(high_len(32'(ratio)));
  assign boundary = run && (cnt == ratio - DIV_W'(1));

  // div_clk is computed from the count it is about to hold, so it stays registered
  // and aligned with cnt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      div_clk <= 1'b0;
      tick    <= 1'b0;
    end else if (start) begin
      cnt     <= '0;
      div_clk <= 1'b1;
      tick    <= 1'b1;
    end else if (run && !boundary) begin
      cnt     <= cnt_inc[DIV_W-1:0];
      div_clk <= (cnt_inc < high_cnt);
      tick    <= 1'b0;
    end else begin
      cnt     <= '0;
      div_clk <= 1'b0;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable integer clock divider controller.
//   clk, reset  - system clock, asynchronous active-high reset
//   en          - level-sensitive run request
//   cfg_valid   - new ratio offered on cfg_div
//   cfg_div     - offered ratio N
//   cfg_ready   - a ratio can be accepted (low while one is pending)
//   cfg_err     - one-cycle pulse after a rejected ratio (N < 2)
//   div_clk     - divided waveform
//   tick        - one-cycle pulse on the first cycle of each div_clk period
//   running     - high while in RUN
//   cur_div     - ratio currently in effect
// Ratios are only applied at a period boundary or while idle, so a period in
// flight is never shortened or stretched.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_clk,
  output logic             tick,
  output logic             running,
  output logic [DIV_W-1:0] cur_div
);

  if (DEFAULT_DIV < MIN_DIV || DEFAULT_DIV >= 2**DIV_W) begin : g_bad_default
    $error("clk_div_ctrl: DEFAULT_DIV must be >= 2 and < 2**DIV_W");
  end

  state_t           state;
  state_t           state_nxt;
  logic             boundary;
  logic             start;
  logic             apply;
  logic             run;
  logic             xfer;
  logic             pend_valid;
  logic [DIV_W-1:0] pend_div;

  assign cfg_ready = !pend_valid;
  assign xfer      = cfg_valid && cfg_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: a period already started always completes before IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (en)              state_nxt = RUN;
      RUN:  if (boundary && !en) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    run     = (state == RUN);
    running = run;
    start   = en && ((state == IDLE) || boundary);
    apply   = pend_valid && ((state == IDLE) || boundary);
  end

  // Pending ratio; a ratio accepted on a boundary cycle waits for the next one
  // because pend_valid is only seen from the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_div   <= '0;
    end else if (apply) begin
      pend_valid <= 1'b0;
    end else if (xfer && (cfg_div >= DIV_W'(MIN_DIV))) begin
      pend_valid <= 1'b1;
      pend_div   <= cfg_div;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_div <= DIV_W'(DEFAULT_DIV);
      cfg_err <= 1'b0;
    end else begin
      if (apply) cur_div <= pend_div;
      cfg_err <= xfer && (cfg_div < DIV_W'(MIN_DIV));
    end
  end

  clk_div_core #(
    .DIV_W(DIV_W)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .ratio    (cur_div),
    .run      (run),
    .start    (start),
    .div_clk  (div_clk),
    .tick     (tick),
    .boundary (boundary)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_div = '0;
  logic       cfg_ready;
  logic       cfg_err;
  logic       div_clk;
  logic       tick;
  logic       running;
  logic [7:0] cur_div;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  clk_div_ctrl #(
    .DIV_W(8),
    .DEFAULT_DIV(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .div_clk   (div_clk),
    .tick      (tick),
    .running   (running),
    .cur_div   (cur_div)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each started period is laid out as a list of its div_clk values; one is
  // consumed per cycle, and the period ends when the last one is showing.
  bit m_run;
  bit m_wave[$];
  int m_cur;
  bit m_pv;
  int m_pd;
  bit m_err;
  bit m_tick;

  function automatic void model_reset();
    m_run = 0;
    m_wave.delete();
    m_cur = 3;
    m_pv  = 0;
    m_pd  = 0;
    m_err = 0;
    m_tick = 0;
  endfunction

  function automatic void model_step(bit e, bit v, int d);
    bit bnd;
    bit xfer;
    bit app;
    bit dummy;
    int n_eff;
    bnd   = m_run && (m_wave.size() == 1);
    xfer  = v && !m_pv;
    app   = m_pv && (!m_run || bnd);
    n_eff = app ? m_pd : m_cur;
    if (!m_run || bnd) begin
      m_wave.delete();
      if (e) begin
        m_run = 1;
        for (int i = 0; i < n_eff; i++) m_wave.push_back(i < (n_eff + 1) / 2);
        m_tick = 1;
      end else begin
        m_run  = 0;
        m_tick = 0;
      end
    end else begin
      dummy  = m_wave.pop_front();
      m_tick = 0;
    end
    m_cur = n_eff;
    if (app) m_pv = 0;
    if (xfer && d >= 2) begin
      m_pv = 1;
      m_pd = d;
    end
    m_err = xfer && (d < 2);
  endfunction

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endfunction

  function automatic void check_model();
    int exp_dc;
    exp_dc = (m_run && m_wave.size() > 0) ? int'(m_wave[0]) : 0;
    chk("div_clk", int'(div_clk), exp_dc);
    chk("tick", int'(tick), int'(m_tick));
    chk("running", int'(running), int'(m_run));
    chk("cfg_ready", int'(cfg_ready), int'(!m_pv));
    chk("cfg_err", int'(cfg_err), int'(m_err));
    chk("cur_div", int'(cur_div), m_cur);
  endfunction

  function automatic void check_reset_vals(string tag);
    chk({tag, "_div_clk"}, int'(div_clk), 0);
    chk({tag, "_tick"}, int'(tick), 0);
    chk({tag, "_running"}, int'(running), 0);
    chk({tag, "_cfg_err"}, int'(cfg_err), 0);
    chk({tag, "_cfg_ready"}, int'(cfg_ready), 1);
    chk({tag, "_cur_div"}, int'(cur_div), 3);
  endfunction

  task automatic step(input bit e, input bit v, input int d);
    en        = e;
    cfg_valid = v;
    cfg_div   = 8'(d);
    @(posedge clk);
    model_step(e, v, d);
    cyc++;
    #1;
    check_model();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit en;
    bit v;
    int d;
    bit dc;
    bit tk;
    bit rn;
    bit rdy;
    bit er;
    int cur;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit e, bit v, int d, bit dc, bit tk, bit rn, bit rdy, bit er, int cur);
    vec_t t;
    t.en = e; t.v = v; t.d = d; t.dc = dc; t.tk = tk;
    t.rn = rn; t.rdy = rdy; t.er = er; t.cur = cur;
    tbl.push_back(t);
  endfunction

  initial begin
    int hi;
    int lo;
    int guard;
    bit seen;

    // inputs, then outputs expected after the clock edge
    add(0,0,0, 0,0,0,1,0,3);
    add(1,0,0, 1,1,1,1,0,3);  // first high one cycle after en sampled
    add(1,0,0, 1,0,1,1,0,3);
    add(1,0,0, 0,0,1,1,0,3);
    add(1,0,0, 1,1,1,1,0,3);
    add(1,1,1, 1,0,1,1,1,3);  // ratio 1 rejected
    add(1,0,0, 0,0,1,1,0,3);
    add(1,0,0, 1,1,1,1,0,3);
    add(1,1,4, 1,0,1,0,0,3);  // ratio 4 offered at cnt=0
    add(1,0,0, 0,0,1,0,0,3);
    add(1,0,0, 1,1,1,1,0,4);  // applied at boundary
    add(1,0,0, 1,0,1,1,0,4);
    add(1,0,0, 0,0,1,1,0,4);
    add(1,0,0, 0,0,1,1,0,4);
    add(1,0,0, 1,1,1,1,0,4);
    add(0,0,0, 1,0,1,1,0,4);  // en dropped at cnt=0, period completes
    add(0,0,0, 0,0,1,1,0,4);
    add(0,0,0, 0,0,1,1,0,4);
    add(0,0,0, 0,0,0,1,0,4);
    add(0,0,0, 0,0,0,1,0,4);
    add(0,1,5, 0,0,0,0,0,4);  // accepted in IDLE
    add(0,0,0, 0,0,0,1,0,5);
    add(1,0,0, 1,1,1,1,0,5);
    add(1,0,0, 1,0,1,1,0,5);
    add(1,0,0, 1,0,1,1,0,5);
    add(1,0,0, 0,0,1,1,0,5);
    add(1,0,0, 0,0,1,1,0,5);
    add(1,0,0, 1,1,1,1,0,5);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("init");
    reset = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].v, tbl[i].d);
      chk("t_div_clk", int'(div_clk), int'(tbl[i].dc));
      chk("t_tick", int'(tick), int'(tbl[i].tk));
      chk("t_running", int'(running), int'(tbl[i].rn));
      chk("t_cfg_ready", int'(cfg_ready), int'(tbl[i].rdy));
      chk("t_cfg_err", int'(cfg_err), int'(tbl[i].er));
      chk("t_cur_div", int'(cur_div), tbl[i].cur);
    end

    // maximum ratio: 128 high, 127 low
    step(1, 1, 255);
    seen = 0;
    for (int k = 0; k < 600 && !seen; k++) begin
      step(1, 0, 0);
      if (tick && cur_div == 8'd255) seen = 1;
    end
    chk("wait_255", int'(seen), 1);
    hi = 0;
    lo = 0;
    guard = 0;
    while (div_clk && guard < 300) begin
      hi++; guard++;
      step(1, 0, 0);
    end
    while (!div_clk && !tick && guard < 600) begin
      lo++; guard++;
      step(1, 0, 0);
    end
    chk("n255_high", hi, 128);
    chk("n255_low", lo, 127);
    chk("n255_tick", int'(tick), 1);

    // N=4 with another ratio pending, then asynchronous reset mid-period
    step(1, 1, 4);
    seen = 0;
    for (int k = 0; k < 600 && !seen; k++) begin
      step(1, 0, 0);
      if (tick && cur_div == 8'd4) seen = 1;
    end
    chk("wait_4", int'(seen), 1);
    step(1, 1, 7);
    step(1, 0, 0);
    chk("pend_ready", int'(cfg_ready), 0);
    #3 reset = 1'b1;
    #1;
    check_reset_vals("async");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_vals("held");
    reset = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("post_rst_cur", int'(cur_div), 3);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("post_rst_period", int'(tick), 1);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      bit e;
      bit v;
      int d;
      e = ($urandom_range(0, 9) != 0);
      v = ($urandom_range(0, 7) == 0);
      d = ($urandom_range(0, 15) < 12) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 255));
      step(e, v, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
